// File: rtl/fifo_ctrl_pkg.sv
// Shared defaults and helpers for the FIFO controller slice.
package fifo_ctrl_pkg;

    localparam int FIFO_DATA_WIDTH = 8;
    localparam int FIFO_ADDR_WIDTH = 4;
    localparam int FIFO_RAM_DEPTH  = 16;

    // Number of RAM entries addressable with aw address bits.
    function automatic int fifo_depth(input int aw);
        return 1 << aw;
    endfunction

endpackage

// File: rtl/fifo_ctrl_if.sv
// Valid/ready word stream; master drives the word, slave answers with ready.
interface fifo_ctrl_if
    import fifo_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH
);
    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/fifo_ram.sv
// Simple dual-port storage with registered read; a write aimed at the
// address being read in the same cycle is suppressed.
module fifo_ram
    import fifo_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int RAM_DEPTH  = FIFO_RAM_DEPTH,
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  w_en,
    input  logic [ADDR_WIDTH-1:0] w_addr,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic                  r_en,
    input  logic [ADDR_WIDTH-1:0] r_addr,
    output logic [DATA_WIDTH-1:0] r_data
);
    logic [DATA_WIDTH-1:0] mem_reg [RAM_DEPTH];
    logic [DATA_WIDTH-1:0] r_data_reg;

    always_ff @(posedge clk) begin
        if (w_en && (w_addr != r_addr)) begin
            mem_reg[w_addr] <= w_data;
        end
        if (r_en) begin
            r_data_reg <= mem_reg[r_addr];
        end
    end

    assign r_data = r_data_reg;
endmodule

// File: rtl/fifo_top.sv
// Thin wrapper pairing one fifo_ctrl with its fifo_ram storage.
module fifo_top
    import fifo_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int RAM_DEPTH  = FIFO_RAM_DEPTH,
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    fifo_ctrl_if.slave          in_if,
    fifo_ctrl_if.master         out_if,
    output logic [ADDR_WIDTH:0] level,
    output logic                full,
    output logic                empty
);
    logic                  ram_w_en;
    logic [ADDR_WIDTH-1:0] ram_w_addr;
    logic [DATA_WIDTH-1:0] ram_w_data;
    logic                  ram_r_en;
    logic [ADDR_WIDTH-1:0] ram_r_addr;
    logic [DATA_WIDTH-1:0] ram_r_data;

    fifo_ctrl #(
        .DATA_WIDTH(DATA_WIDTH),
        .RAM_DEPTH (RAM_DEPTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_if     (in_if),
        .out_if    (out_if),
        .level     (level),
        .full      (full),
        .empty     (empty),
        .ram_w_en  (ram_w_en),
        .ram_w_addr(ram_w_addr),
        .ram_w_data(ram_w_data),
        .ram_r_en  (ram_r_en),
        .ram_r_addr(ram_r_addr),
        .ram_r_data(ram_r_data)
    );

    fifo_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .RAM_DEPTH (RAM_DEPTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .w_en  (ram_w_en),
        .w_addr(ram_w_addr),
        .w_data(ram_w_data),
        .r_en  (ram_r_en),
        .r_addr(ram_r_addr),
        .r_data(ram_r_data)
    );
endmodule

// File: rtl/fifo_ctrl.sv
// FIFO controller: sequences fifo_ram into a first-word-fall-through
// valid/ready FIFO holding up to RAM_DEPTH+1 words.
module fifo_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int RAM_DEPTH  = FIFO_RAM_DEPTH,
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    fifo_ctrl_if.slave            in_if,
    fifo_ctrl_if.master           out_if,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  full,
    output logic                  empty,
    output logic                  ram_w_en,
    output logic [ADDR_WIDTH-1:0] ram_w_addr,
    output logic [DATA_WIDTH-1:0] ram_w_data,
    output logic                  ram_r_en,
    output logic [ADDR_WIDTH-1:0] ram_r_addr,
    input  logic [DATA_WIDTH-1:0] ram_r_data
);
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(RAM_DEPTH);

    logic [ADDR_WIDTH-1:0] wr_ptr_reg, wr_ptr_next;
    logic [ADDR_WIDTH-1:0] rd_ptr_reg, rd_ptr_next;
    logic [ADDR_WIDTH:0]   count_reg, count_next;
    logic                  out_valid_reg, out_valid_next;

    logic in_ready;
    logic push;
    logic pop;
    logic fetch;

    // Capacity is judged on the RAM alone: refusing a push into a full RAM,
    // even while popping, keeps the write and read pointers apart.
    assign in_ready = !flush && (count_reg < DEPTH_L);
    assign push     = in_if.valid && in_ready;
    assign pop      = out_valid_reg && out_if.ready;
    assign fetch    = !flush && (count_reg != '0) && (!out_valid_reg || out_if.ready);

    assign in_if.ready  = in_ready;
    assign out_if.valid = out_valid_reg;
    assign out_if.data  = ram_r_data;

    assign ram_w_en   = push;
    assign ram_w_addr = wr_ptr_reg;
    assign ram_w_data = in_if.data;
    assign ram_r_en   = fetch;
    // Idle read address is parked on the complement of the write pointer so
    // the RAM never sees a same-address read while a word is written.
    assign ram_r_addr = fetch ? rd_ptr_reg : ~wr_ptr_reg;

    assign level = count_reg + {{ADDR_WIDTH{1'b0}}, out_valid_reg};
    assign full  = (count_reg == DEPTH_L);
    assign empty = (level == '0);

    always_comb begin
        wr_ptr_next    = wr_ptr_reg;
        rd_ptr_next    = rd_ptr_reg;
        count_next     = count_reg;
        out_valid_next = out_valid_reg;
        if (flush) begin
            wr_ptr_next    = '0;
            rd_ptr_next    = '0;
            count_next     = '0;
            out_valid_next = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_next = wr_ptr_reg + ADDR_WIDTH'(1);
            end
            if (fetch) begin
                rd_ptr_next = rd_ptr_reg + ADDR_WIDTH'(1);
            end
            count_next = count_reg + {{ADDR_WIDTH{1'b0}}, push}
                                   - {{ADDR_WIDTH{1'b0}}, fetch};
            if (fetch) begin
                out_valid_next = 1'b1;
            end else if (pop) begin
                out_valid_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            count_reg     <= count_next;
            out_valid_reg <= out_valid_next;
        end
    end

    // Pointer wrap relies on the RAM depth being an exact power of two.
    always_ff @(posedge clk) begin
        assert (RAM_DEPTH == fifo_depth(ADDR_WIDTH))
            else $error("fifo_ctrl: RAM_DEPTH %0d is not 2**ADDR_WIDTH", RAM_DEPTH);
    end
endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed and random stimulus for fifo_ctrl against a word-queue model.
module tb_fifo_ctrl;
    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          flush = 1'b0;
    logic [AW:0]   level;
    logic          full;
    logic          empty;
    logic          ram_w_en;
    logic [AW-1:0] ram_w_addr;
    logic [DW-1:0] ram_w_data;
    logic          ram_r_en;
    logic [AW-1:0] ram_r_addr;
    logic [DW-1:0] ram_r_data;

    fifo_ctrl_if #(.DATA_WIDTH(DW)) in_bus ();
    fifo_ctrl_if #(.DATA_WIDTH(DW)) out_bus ();

    fifo_ctrl #(.DATA_WIDTH(DW), .RAM_DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_if     (in_bus),
        .out_if    (out_bus),
        .level     (level),
        .full      (full),
        .empty     (empty),
        .ram_w_en  (ram_w_en),
        .ram_w_addr(ram_w_addr),
        .ram_w_data(ram_w_data),
        .ram_r_en  (ram_r_en),
        .ram_r_addr(ram_r_addr),
        .ram_r_data(ram_r_data)
    );

    fifo_ram #(.DATA_WIDTH(DW), .RAM_DEPTH(DEPTH), .ADDR_WIDTH(AW)) u_ram (
        .clk   (clk),
        .w_en  (ram_w_en),
        .w_addr(ram_w_addr),
        .w_data(ram_w_data),
        .r_en  (ram_r_en),
        .r_addr(ram_r_addr),
        .r_data(ram_r_data)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: words sitting in storage, plus the presented head word.
    logic [DW-1:0] m_q[$];
    bit            m_ov = 1'b0;
    logic [DW-1:0] m_head = '0;

    logic [DW-1:0] got[$];
    logic [DW-1:0] sent[$];
    bit            track = 1'b0;
    bit            seen = 1'b0;
    int            bubbles = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; drives one cycle, checks it, returns at the next falling edge.
    task automatic step(input bit iv, input logic [DW-1:0] id, input bit ordy, input bit fl);
        bit m_push, m_fetch, m_pop;
        int lvl;
        in_bus.valid  = iv;
        in_bus.data   = id;
        out_bus.ready = ordy;
        flush         = fl;
        #1;
        m_push  = iv && !fl && (m_q.size() < DEPTH);
        m_fetch = !fl && (m_q.size() != 0) && (!m_ov || ordy);
        m_pop   = m_ov && ordy;
        lvl     = m_q.size() + int'(m_ov);
        chk("in_ready", 32'(in_bus.ready), 32'(!fl && (m_q.size() < DEPTH)));
        chk("out_valid", 32'(out_bus.valid), 32'(m_ov));
        chk("level", 32'(level), 32'(lvl));
        chk("full", 32'(full), 32'(m_q.size() == DEPTH));
        chk("empty", 32'(empty), 32'(lvl == 0));
        chk("ram_w_en", 32'(ram_w_en), 32'(m_push));
        chk("ram_r_en", 32'(ram_r_en), 32'(m_fetch));
        if (m_ov) chk("out_data", 32'(out_bus.data), 32'(m_head));
        if (ram_w_en) chk("addr_sep", 32'(ram_r_addr != ram_w_addr), 32'd1);
        if (track) begin
            if (out_bus.valid) seen = 1'b1;
            else if (seen) bubbles++;
        end
        if (m_pop) begin
            got.push_back(out_bus.data);
            $display("pop  data=%02h level=%0d", out_bus.data, level);
        end
        if (m_push) $display("push data=%02h level=%0d", id, level);
        @(posedge clk);
        if (fl) begin
            m_q.delete();
            m_ov = 1'b0;
        end else begin
            if (m_fetch) begin
                m_head = m_q.pop_front();
                m_ov   = 1'b1;
            end else if (m_pop) begin
                m_ov = 1'b0;
            end
            if (m_push) m_q.push_back(id);
        end
        @(negedge clk);
    endtask

    initial begin
        in_bus.valid  = 1'b0;
        in_bus.data   = '0;
        out_bus.ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_out_valid", 32'(out_bus.valid), 32'd0);
        chk("rst_in_ready", 32'(in_bus.ready), 32'd1);
        chk("rst_ram_en", 32'({ram_w_en, ram_r_en}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Single word fall-through latency
        step(1'b1, 8'hA5, 1'b0, 1'b0);
        chk("lat1_out_valid", 32'(out_bus.valid), 32'd0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("lat2_out_valid", 32'(out_bus.valid), 32'd1);
        chk("lat2_out_data", 32'(out_bus.data), 32'hA5);
        chk("lat2_level", 32'(level), 32'd1);
        chk("lat2_empty", 32'(empty), 32'd0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);

        // Fill to capacity, then pop and push together against a full RAM
        got.delete();
        for (int i = 0; i < 17; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_level", 32'(level), 32'd17);
        chk("fill_in_ready", 32'(in_bus.ready), 32'd0);
        step(1'b1, 8'h11, 1'b0, 1'b0);
        step(1'b1, 8'h55, 1'b1, 1'b0);
        chk("fullpop_level", 32'(level), 32'd16);
        chk("fullpop_in_ready", 32'(in_bus.ready), 32'd1);
        step(1'b1, 8'h55, 1'b0, 1'b0);
        chk("refill_level", 32'(level), 32'd17);
        for (int i = 0; i < 22; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("drain_count", 32'(got.size()), 32'd18);
        for (int i = 0; i < 18 && i < got.size(); i++)
            chk("drain_order", 32'(got[i]), (i < 17) ? 32'(i) : 32'h55);
        chk("drain_empty", 32'(empty), 32'd1);

        // Streaming: one push and one pop per cycle
        got.delete();
        sent.delete();
        track = 1'b1;
        seen = 1'b0;
        bubbles = 0;
        for (int i = 0; i < 100; i++) begin
            logic [DW-1:0] w;
            w = 8'($urandom);
            sent.push_back(w);
            step(1'b1, w, 1'b1, 1'b0);
        end
        track = 1'b0;
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("stream_bubbles", 32'(bubbles), 32'd0);
        chk("stream_count", 32'(got.size()), 32'd100);
        for (int i = 0; i < 100 && i < got.size(); i++)
            chk("stream_order", 32'(got[i]), 32'(sent[i]));

        // Flush with words held and a simultaneous push
        got.delete();
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
        step(1'b1, 8'h77, 1'b0, 1'b1);
        chk("flush_level", 32'(level), 32'd0);
        chk("flush_out_valid", 32'(out_bus.valid), 32'd0);
        step(1'b1, 8'h3C, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("flush_first_count", 32'(got.size()), 32'd1);
        if (got.size() > 0) chk("flush_first_word", 32'(got[0]), 32'h3C);

        // Random mix with occasional flush
        for (int i = 0; i < 300; i++)
            step(1'($urandom), 8'($urandom), 1'($urandom), $urandom_range(0, 31) == 0);
        for (int i = 0; i < 20; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

        // Asynchronous reset while 8 words are held
        for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
        in_bus.valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_level", 32'(level), 32'd0);
        chk("arst_empty", 32'(empty), 32'd1);
        chk("arst_out_valid", 32'(out_bus.valid), 32'd0);
        m_q.delete();
        m_ov = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        got.delete();
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("post_rst_count", 32'(got.size()), 32'd3);
        for (int i = 0; i < 3 && i < got.size(); i++)
            chk("post_rst_order", 32'(got[i]), 32'(8'hC0 + i));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
